// File: rtl/ram_cmd_initiator_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_cmd_initiator_if : request/response and RAM command-stream bundle      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface ram_cmd_initiator_if #(
  parameter int PAYLOAD_W = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [PAYLOAD_W-1:0] req_addr;
  logic [PAYLOAD_W-1:0] req_wdata;
  logic                 rsp_valid;
  logic [PAYLOAD_W-1:0] rsp_rdata;
  logic                 rsp_timeout;
  logic [PAYLOAD_W+1:0] ram_din;
  logic                 ram_rx_valid;
  logic [PAYLOAD_W-1:0] ram_dout;
  logic                 ram_tx_valid;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, ram_dout, ram_tx_valid,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout, ram_din, ram_rx_valid
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, ram_dout, ram_tx_valid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout, ram_din, ram_rx_valid
  );
endinterface
`default_nettype wire

// File: rtl/ram_cmd_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_cmd_initiator : turns one write/read request into the RAM's 2-bit      |
// | opcode command stream and returns the read byte.           Rev 1.0        |
// +----------------------------------------------------------------------------+
module ram_cmd_initiator #(
  parameter int PAYLOAD_W = 8,
  parameter int TIMEOUT   = 16
) (
  input wire                 clk,
  input wire                 rst,
  ram_cmd_initiator_if.master bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] c_CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] c_OP_WR_ADDR = 2'b00;
  localparam logic [1:0] c_OP_WR_DATA = 2'b01;
  localparam logic [1:0] c_OP_RD_ADDR = 2'b10;
  localparam logic [1:0] c_OP_RD      = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_CMD  = 3'd4,
    S_RD_WAIT = 3'd5,
    S_RSP     = 3'd6
  } state_t;

  state_t               r_state;
  logic [PAYLOAD_W+1:0] r_din;
  logic                 r_rx_valid;
  logic                 r_rsp_valid;
  logic [PAYLOAD_W-1:0] r_rsp_rdata;
  logic                 r_rsp_timeout;
  logic [CNT_W-1:0]     r_cnt;
  logic [PAYLOAD_W-1:0] r_wdata;

  state_t               w_state_nxt;
  logic [PAYLOAD_W+1:0] w_din_nxt;
  logic                 w_rx_valid_nxt;
  logic                 w_rsp_valid_nxt;
  logic [PAYLOAD_W-1:0] w_rsp_rdata_nxt;
  logic                 w_rsp_timeout_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [PAYLOAD_W-1:0] w_wdata_nxt;
  logic                 w_req_ready;
  logic                 w_accept;

  assign w_req_ready = (r_state == S_IDLE) & ~rst;
  assign w_accept    = bus.req_valid & w_req_ready;

  // Every output is computed one state ahead so the command word is on the
  // bus in the first cycle after the accepting edge.
  always_comb begin
    w_state_nxt       = r_state;
    w_din_nxt         = r_din;
    w_rx_valid_nxt    = 1'b0;
    w_rsp_valid_nxt   = 1'b0;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_cnt_nxt         = r_cnt;
    w_wdata_nxt       = r_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_wdata_nxt    = bus.req_wdata;
          w_rx_valid_nxt = 1'b1;
          if (bus.req_write) begin
            w_state_nxt = S_WR_ADDR;
            w_din_nxt   = {c_OP_WR_ADDR, bus.req_addr};
          end else begin
            w_state_nxt = S_RD_ADDR;
            w_din_nxt   = {c_OP_RD_ADDR, bus.req_addr};
          end
        end
      end
      S_WR_ADDR: begin
        w_state_nxt    = S_WR_DATA;
        w_din_nxt      = {c_OP_WR_DATA, r_wdata};
        w_rx_valid_nxt = 1'b1;
      end
      S_WR_DATA: begin
        w_state_nxt       = S_RSP;
        w_rsp_valid_nxt   = 1'b1;
        w_rsp_rdata_nxt   = '0;
        w_rsp_timeout_nxt = 1'b0;
      end
      S_RD_ADDR: begin
        w_state_nxt    = S_RD_CMD;
        w_din_nxt      = {c_OP_RD, {PAYLOAD_W{1'b0}}};
        w_rx_valid_nxt = 1'b1;
      end
      S_RD_CMD: begin
        w_state_nxt = S_RD_WAIT;
        w_cnt_nxt   = '0;
      end
      S_RD_WAIT: begin
        // Data arriving on the limit cycle takes priority over the timeout.
        if (bus.ram_tx_valid) begin
          w_state_nxt       = S_RSP;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_rdata_nxt   = bus.ram_dout;
          w_rsp_timeout_nxt = 1'b0;
        end else if (r_cnt == c_CNT_LIMIT) begin
          w_state_nxt       = S_RSP;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_rdata_nxt   = '0;
          w_rsp_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RSP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_din         <= '0;
      r_rx_valid    <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
      r_cnt         <= '0;
      r_wdata       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_din         <= w_din_nxt;
      r_rx_valid    <= w_rx_valid_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_cnt         <= w_cnt_nxt;
      r_wdata       <= w_wdata_nxt;
    end
  end

  assign bus.req_ready    = w_req_ready;
  assign bus.ram_din      = r_din;
  assign bus.ram_rx_valid = r_rx_valid;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = r_rsp_rdata;
  assign bus.rsp_timeout  = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ram_cmd_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ram_cmd_initiator : directed bench with a behavioural command RAM       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ram_cmd_initiator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_cmd_initiator_if #(.PAYLOAD_W(8)) bus ();

  ram_cmd_initiator #(.PAYLOAD_W(8), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural RAM: answers a read command with tx_valid one cycle later.
  logic [7:0] mem [256];
  logic [7:0] m_waddr, m_raddr, m_dout;
  logic       m_tx;
  logic       ram_en    = 1'b1;
  logic       force_en  = 1'b0;
  logic       force_tx  = 1'b0;
  logic [7:0] force_dout = 8'h00;

  always @(posedge clk) begin
    m_tx <= 1'b0;
    if (bus.ram_rx_valid) begin
      case (bus.ram_din[9:8])
        2'b00: m_waddr <= bus.ram_din[7:0];
        2'b01: mem[m_waddr] <= bus.ram_din[7:0];
        2'b10: m_raddr <= bus.ram_din[7:0];
        default: begin
          m_tx   <= 1'b1;
          m_dout <= mem[m_raddr];
        end
      endcase
    end
  end

  assign bus.ram_tx_valid = force_en ? force_tx   : (ram_en & m_tx);
  assign bus.ram_dout     = force_en ? force_dout : m_dout;

  typedef struct {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       ram_en;
    logic [9:0] din0;
    logic [9:0] din1;
    int         lat;
    logic [7:0] rdata;
    logic       to;
  } vec_t;

  vec_t vecs[7];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  // Called at #1 after a rising edge with the DUT idle.
  task automatic run_req(input vec_t v, input string nm);
    int lat;
    bit got;
    ram_en = v.ram_en;
    check({nm, "_ready"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = v.write;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_write = ~v.write;
    bus.req_addr  = ~v.addr;
    bus.req_wdata = ~v.wdata;
    check({nm, "_din0"}, bus.ram_din, v.din0);
    check({nm, "_rx0"}, bus.ram_rx_valid, 1);
    @(posedge clk); #1;
    check({nm, "_din1"}, bus.ram_din, v.din1);
    check({nm, "_rx1"}, bus.ram_rx_valid, 1);
    @(posedge clk); #1;
    check({nm, "_rx2"}, bus.ram_rx_valid, 0);
    lat = 2;
    got = 0;
    while (!got && lat < 40) begin
      if (bus.rsp_valid) got = 1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check({nm, "_lat"}, lat, v.lat);
    check({nm, "_rdata"}, bus.rsp_rdata, v.rdata);
    check({nm, "_timeout"}, bus.rsp_timeout, v.to);
    check({nm, "_dinhold"}, bus.ram_din, v.din1);
    @(posedge clk); #1;
    check({nm, "_pulse"}, bus.rsp_valid, 0);
    check({nm, "_ready_after"}, bus.req_ready, 1);
    check({nm, "_rdata_hold"}, bus.rsp_rdata, v.rdata);
    ram_en = 1'b1;
  endtask

  logic [9:0] din_log [8];
  logic [8:0] rsp_log [4];
  int         acc_cyc [2];
  int         n_acc, n_din, n_rsp, lat;
  bit         got;

  initial begin
    vecs[0] = '{1'b1, 8'h12, 8'h3C, 1'b1, 10'h012, 10'h13C, 2,  8'h00, 1'b0};
    vecs[1] = '{1'b0, 8'h12, 8'h00, 1'b1, 10'h212, 10'h300, 3,  8'h3C, 1'b0};
    vecs[2] = '{1'b1, 8'hFF, 8'hA5, 1'b1, 10'h0FF, 10'h1A5, 2,  8'h00, 1'b0};
    vecs[3] = '{1'b0, 8'hFF, 8'h77, 1'b1, 10'h2FF, 10'h300, 3,  8'hA5, 1'b0};
    vecs[4] = '{1'b1, 8'h00, 8'h81, 1'b1, 10'h000, 10'h181, 2,  8'h00, 1'b0};
    vecs[5] = '{1'b0, 8'h12, 8'h00, 1'b0, 10'h212, 10'h300, 18, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 8'h00, 1'b1, 10'h200, 10'h300, 3,  8'h81, 1'b0};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.req_ready, 0);
    check("rst_rx", bus.ram_rx_valid, 0);
    check("rst_din", bus.ram_din, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rdata", bus.rsp_rdata, 0);
    check("rst_timeout", bus.rsp_timeout, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_req(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: req_valid held, write then read queued.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'h40;
    bus.req_wdata = 8'h5A;
    n_acc = 0; n_din = 0; n_rsp = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bus.ram_rx_valid) begin
        if (n_din < 8) din_log[n_din] = bus.ram_din;
        n_din++;
      end
      if (bus.rsp_valid) begin
        if (n_rsp < 4) rsp_log[n_rsp] = {bus.rsp_timeout, bus.rsp_rdata};
        n_rsp++;
      end
      if (bus.req_valid && bus.req_ready) begin
        if (n_acc < 2) acc_cyc[n_acc] = c;
        n_acc++;
      end
      @(posedge clk); #1;
      if (n_acc == 1) begin
        bus.req_write = 1'b0;
        bus.req_wdata = 8'hEE;
      end
      if (n_acc >= 2) bus.req_valid = 1'b0;
    end
    check("b2b_accepts", n_acc, 2);
    check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 4);
    check("b2b_ndin", n_din, 4);
    check("b2b_din0", din_log[0], 10'h040);
    check("b2b_din1", din_log[1], 10'h15A);
    check("b2b_din2", din_log[2], 10'h240);
    check("b2b_din3", din_log[3], 10'h300);
    check("b2b_nrsp", n_rsp, 2);
    check("b2b_rsp0", rsp_log[0], 9'h000);
    check("b2b_rsp1", rsp_log[1], 9'h05A);

    // Stale tx_valid during IDLE and RD_ADDR must be ignored.
    force_en = 1'b1; force_tx = 1'b1; force_dout = 8'hAA;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h12;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    force_en = 1'b0;
    lat = 1; got = 0;
    while (!got && lat < 40) begin
      if (bus.rsp_valid) got = 1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check("stale_lat", lat, 3);
    check("stale_rdata", bus.rsp_rdata, 8'h3C);
    check("stale_timeout", bus.rsp_timeout, 0);
    @(posedge clk); #1;

    // Reset asserted during RD_CMD.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'hFF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_rx_before", bus.ram_rx_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rx", bus.ram_rx_valid, 0);
    check("mid_din", bus.ram_din, 0);
    check("mid_rsp_valid", bus.rsp_valid, 0);
    check("mid_rdata", bus.rsp_rdata, 0);
    check("mid_timeout", bus.rsp_timeout, 0);
    check("mid_ready", bus.req_ready, 0);
    @(negedge clk);
    check("mid_ready_hold", bus.req_ready, 0);
    rst = 1'b0;
    #1;
    check("mid_ready_release", bus.req_ready, 1);
    @(posedge clk); #1;
    run_req(vecs[1], "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
